// File: rtl/ddsm_frac_ctrl.sv
// Sequencing controller for the delta-sigma EFM cascade: word load, flush, run.
// Optional DDSM_CTRL_DITHER_EN adds an LFSR dither on o_efm_data[0].
module ddsm_frac_ctrl #(
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_FLUSH_CYCLES = 4,
    parameter int P_HOLD_CYCLES  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_frac_word,
    input  logic                    i_frac_valid,
    output logic                    o_frac_ready,
    input  logic [7:0]              i_seed,
    input  logic                    i_enable,
    output logic [P_DATA_WIDTH-1:0] o_efm_data,
    output logic [7:0]              o_seed,
    output logic                    o_mod_rst_n,
    output logic                    o_mod_valid,
    output logic [1:0]              o_state,
    output logic [7:0]              o_update_cnt
);

    localparam int FW = (P_FLUSH_CYCLES > 1) ? $clog2(P_FLUSH_CYCLES) : 1;
    localparam int HW = (P_HOLD_CYCLES > 0) ? $clog2(P_HOLD_CYCLES + 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(P_FLUSH_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(P_HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t                  state;
    logic [P_DATA_WIDTH-1:0] word_q;
    logic [P_DATA_WIDTH-1:0] efm_q;
    logic [7:0]              seed_q;
    logic                    word_loaded;
    logic [FW-1:0]           flush_cnt;
    logic [HW-1:0]           hold_cnt;
    logic                    hs;

    always_comb begin
        o_frac_ready = 1'b0;
        if (!i_rst) begin
            unique case (state)
                ST_IDLE: o_frac_ready = 1'b1;
                ST_RUN:  o_frac_ready = (hold_cnt == HOLD_MAX);
                default: o_frac_ready = 1'b0;
            endcase
        end
    end

    assign hs      = i_frac_valid && o_frac_ready;
    assign o_state = state;

`ifdef DDSM_CTRL_DITHER_EN
    logic [15:0] lfsr;
    logic        dith_on;
    logic        lfsr_fb;

    // x^16+x^14+x^13+x^11+1, shifting towards the MSB
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign dith_on    = (state == ST_FLUSH) || (state == ST_RUN);
    assign o_efm_data = {efm_q[P_DATA_WIDTH-1:1], efm_q[0] ^ (lfsr[0] & dith_on)};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= '0;
        end else if (i_enable) begin
            if (state == ST_LOAD) begin
                lfsr <= {o_seed, ~o_seed};
            end else if (dith_on) begin
                lfsr <= {lfsr[14:0], lfsr_fb};
            end
        end
    end
`else
    assign o_efm_data = efm_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            word_q       <= '0;
            efm_q        <= '0;
            seed_q       <= '0;
            o_seed       <= '0;
            word_loaded  <= 1'b0;
            o_mod_rst_n  <= 1'b0;
            o_mod_valid  <= 1'b0;
            o_update_cnt <= '0;
            flush_cnt    <= '0;
            hold_cnt     <= '0;
        end else begin
            if (hs) begin
                word_q       <= i_frac_word;
                o_update_cnt <= o_update_cnt + 8'd1;
                if (state == ST_IDLE) begin
                    seed_q      <= i_seed;
                    word_loaded <= 1'b1;
                end
            end
            if (!i_enable) begin
                state       <= ST_IDLE;
                o_mod_rst_n <= 1'b0;
                o_mod_valid <= 1'b0;
                flush_cnt   <= '0;
                hold_cnt    <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        o_mod_rst_n <= 1'b0;
                        o_mod_valid <= 1'b0;
                        // forward a same-cycle word so LOAD already shows it
                        if (word_loaded || hs) begin
                            state  <= ST_LOAD;
                            efm_q  <= hs ? i_frac_word : word_q;
                            o_seed <= hs ? i_seed : seed_q;
                        end
                    end
                    ST_LOAD: begin
                        state       <= ST_FLUSH;
                        o_mod_rst_n <= 1'b1;
                        flush_cnt   <= '0;
                    end
                    ST_FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state       <= ST_RUN;
                            o_mod_valid <= 1'b1;
                            hold_cnt    <= '0;
                        end else begin
                            flush_cnt <= flush_cnt + FW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (hs) begin
                            state       <= ST_FLUSH;
                            efm_q       <= i_frac_word;
                            o_mod_valid <= 1'b0;
                            flush_cnt   <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddsm_frac_ctrl.sv
// Directed bench for ddsm_frac_ctrl at default parameters (flush 4, hold 16).
// Dither expectations switch on DDSM_CTRL_DITHER_EN.
module tb_ddsm_frac_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frac_word;
    logic       frac_valid;
    logic       frac_ready;
    logic [7:0] seed;
    logic       enable;
    logic [7:0] efm_data;
    logic [7:0] seed_out;
    logic       mod_rst_n;
    logic       mod_valid;
    logic [1:0] state;
    logic [7:0] update_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddsm_frac_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frac_word  (frac_word),
        .i_frac_valid (frac_valid),
        .o_frac_ready (frac_ready),
        .i_seed       (seed),
        .i_enable     (enable),
        .o_efm_data   (efm_data),
        .o_seed       (seed_out),
        .o_mod_rst_n  (mod_rst_n),
        .o_mod_valid  (mod_valid),
        .o_state      (state),
        .o_update_cnt (update_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_efm"}, 32'(efm_data), 32'h0);
        chk({tag, "_seed"}, 32'(seed_out), 32'h0);
        chk({tag, "_rstn"}, 32'(mod_rst_n), 32'h0);
        chk({tag, "_valid"}, 32'(mod_valid), 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
        chk({tag, "_cnt"}, 32'(update_cnt), 32'h0);
        chk({tag, "_ready"}, 32'(frac_ready), 32'h0);
    endtask

    initial begin
        logic [15:0] m;
        logic [7:0]  e;

        rst        = 1'b1;
        enable     = 1'b0;
        frac_valid = 1'b0;
        frac_word  = 8'h00;
        seed       = 8'h00;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(frac_ready), 32'h1);

        // IDLE handshake, word 40 seed 5A
        enable     = 1'b1;
        frac_word  = 8'h40;
        seed       = 8'h5A;
        frac_valid = 1'b1;
        tick();
        frac_valid = 1'b0;
        chk("load_state", 32'(state), 32'h1);
        chk("load_efm", 32'(efm_data), 32'h40);
        chk("load_seed", 32'(seed_out), 32'h5A);
        chk("load_rstn", 32'(mod_rst_n), 32'h0);
        chk("load_cnt", 32'(update_cnt), 32'h1);
        chk("load_ready", 32'(frac_ready), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("flush_state", 32'(state), 32'h2);
            chk("flush_rstn", 32'(mod_rst_n), 32'h1);
            chk("flush_valid", 32'(mod_valid), 32'h0);
        end
        tick();
        chk("run_state", 32'(state), 32'h3);
        chk("run_valid", 32'(mod_valid), 32'h1);

        // RUN hold: word offered at RUN cycle 3, ready at cycle 16
        tick();
        tick();
        tick();
        frac_word  = 8'h41;
        seed       = 8'hC3;
        frac_valid = 1'b1;
        for (int c = 3; c <= 15; c++) begin
            chk("hold_ready", 32'(frac_ready), 32'h0);
            chk("hold_rstn", 32'(mod_rst_n), 32'h1);
            tick();
        end
        chk("hold_ready16", 32'(frac_ready), 32'h1);
        tick();
        frac_valid = 1'b0;
        chk("upd_state", 32'(state), 32'h2);
        chk("upd_efm", 32'(efm_data), 32'h41);
        chk("upd_seed", 32'(seed_out), 32'h5A);
        chk("upd_rstn", 32'(mod_rst_n), 32'h1);
        chk("upd_valid", 32'(mod_valid), 32'h0);
        chk("upd_cnt", 32'(update_cnt), 32'h2);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("upd_flush_rstn", 32'(mod_rst_n), 32'h1);
            chk("upd_flush_valid", 32'(mod_valid), 32'h0);
        end
        tick();
        chk("upd_run_state", 32'(state), 32'h3);
        chk("upd_run_valid", 32'(mod_valid), 32'h1);

        // disable from RUN, then re-enable and drop mid-FLUSH
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(state), 32'h0);
        chk("dis_rstn", 32'(mod_rst_n), 32'h0);
        chk("dis_valid", 32'(mod_valid), 32'h0);
        enable = 1'b1;
        tick();
        chk("reload_state", 32'(state), 32'h1);
        chk("reload_efm", 32'(efm_data), 32'h41);
        chk("reload_seed", 32'(seed_out), 32'h5A);
        tick();
        chk("reflush_state", 32'(state), 32'h2);
        tick();
        enable = 1'b0;
        tick();
        chk("midflush_state", 32'(state), 32'h0);
        chk("midflush_rstn", 32'(mod_rst_n), 32'h0);
        enable = 1'b1;
        tick();
        chk("reuse_state", 32'(state), 32'h1);
        tick();
        chk("reuse_flush", 32'(state), 32'h2);
        tick();
        tick();
        tick();
        tick();
        chk("reuse_run", 32'(state), 32'h3);
        chk("reuse_valid", 32'(mod_valid), 32'h1);
        chk("reuse_efm", 32'(efm_data), 32'h41);
        chk("reuse_cnt", 32'(update_cnt), 32'h2);

        // reset pulse in RUN
        rst = 1'b1;
        tick();
        chk_reset_vals("runrst");
        rst = 1'b0;
        tick();
        tick();
        chk("postrst_idle", 32'(state), 32'h0);

        // 256 and 257 accepted words in IDLE
        enable     = 1'b0;
        frac_word  = 8'h80;
        seed       = 8'h00;
        frac_valid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        chk("cnt_255", 32'(update_cnt), 32'hFF);
        tick();
        chk("cnt_wrap", 32'(update_cnt), 32'h0);
        tick();
        chk("cnt_257", 32'(update_cnt), 32'h1);
        frac_valid = 1'b0;

        // word 80, seed 00 through LOAD/FLUSH/RUN
        enable = 1'b1;
        tick();
        chk("dith_load_efm", 32'(efm_data), 32'h80);
        chk("dith_load_seed", 32'(seed_out), 32'h00);
        m = 16'h00FF;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = 8'h80;
`ifdef DDSM_CTRL_DITHER_EN
            e[0] = m[0];
`endif
            chk("dith_efm", 32'(efm_data), 32'(e));
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddsm_frac_ctrl.md
# ddsm_frac_ctrl

Sequencing controller for the delta-sigma modulator's EFM cascade. It accepts fractional frequency words over a valid/ready handshake, holds the modulator in reset while a new seed and word are loaded, and lets the pipeline flush before flagging the quantize stream valid. In-run word updates are applied glitchlessly, without resetting the cascade. It sits between the frequency-control register interface and the first EFM stage's data, seed and reset inputs.

## Interface

- P_DATA_WIDTH, 8, width of the fractional word and modulator input
- P_FLUSH_CYCLES, 4, cycles the output is invalid after any word change; minimum 1; equals the cascade pipeline depth
- P_HOLD_CYCLES, 16, minimum RUN cycles before a new word is accepted; 0 allowed

- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_frac_word  in  P_DATA_WIDTH  fractional word
- i_frac_valid  in  1  word valid
- o_frac_ready  out  1  word accepted when valid && ready
- i_seed  in  8  modulator seed, sampled on IDLE handshakes only
- i_enable  in  1  run enable
- o_efm_data  out  P_DATA_WIDTH  word driven to the first EFM stage
- o_seed  out  8  seed driven to the cascade
- o_mod_rst_n  out  1  active-low reset to the cascade
- o_mod_valid  out  1  quantize stream trustworthy
- o_state  out  2  IDLE=0, LOAD=1, FLUSH=2, RUN=3
- o_update_cnt  out  8  accepted-word count; wraps 255→0

## Operation

- Reset values: o_efm_data=0, o_seed=0, o_mod_rst_n=0, o_mod_valid=0, o_state=IDLE, o_update_cnt=0. The internal word_loaded flag is 0 and o_frac_ready is 0 while i_rst=1.
- o_frac_ready: 1 in IDLE, 0 in LOAD and FLUSH. In RUN it is 1 only once the hold counter reaches P_HOLD_CYCLES.
- Handshake: latch i_frac_word and increment o_update_cnt. In IDLE only, also latch i_seed and set word_loaded.
- IDLE: o_mod_rst_n=0, o_mod_valid=0.
  - → LOAD if i_enable=1 and (word_loaded or a handshake occurs this cycle).
- LOAD (1 cycle): o_mod_rst_n=0; o_efm_data and o_seed are updated from the latched values. → FLUSH.
- FLUSH: o_mod_rst_n=1, o_mod_valid=0; the flush counter counts P_FLUSH_CYCLES cycles. → RUN.
- RUN: o_mod_valid=1; the hold counter starts at 0 on entry and saturates at P_HOLD_CYCLES.
  - On a handshake: o_efm_data updates the next cycle, o_seed is unchanged, o_mod_rst_n stays 1, and the state goes → FLUSH.
- i_enable=0 in any state: → IDLE the next cycle. o_mod_rst_n=0 and o_mod_valid=0 from that cycle. The latched word and word_loaded are retained.
- A handshake in the same cycle as i_enable falling is still accepted and latched. Priority goes to the IDLE transition.
- i_rst takes priority over everything. A reset mid-FLUSH or mid-RUN returns to the reset values on the next edge.
- Counters restart on every state entry, so there are no partial counts across transitions.

## Timing

- IDLE handshake at edge T with i_enable=1:
  - LOAD at T+1 (o_efm_data=word, o_mod_rst_n=0).
  - FLUSH at T+2 (o_mod_rst_n=1).
  - RUN with o_mod_valid=1 at T+2+P_FLUSH_CYCLES.
- RUN handshake at T: FLUSH and new o_efm_data at T+1; o_mod_valid=0 from T+1; RUN again at T+1+P_FLUSH_CYCLES.
- First RUN-ready cycle is RUN entry + P_HOLD_CYCLES.
- All outputs except o_frac_ready are registered.

## Configuration

- DDSM_CTRL_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 is seeded in LOAD with {o_seed, ~o_seed}, which is never zero.
  - The LFSR advances every FLUSH/RUN cycle.
  - o_efm_data[0] = word[0] XOR lfsr[0].
- Undefined: no LFSR; o_efm_data equals the latched word exactly.

## Test plan

- Reset, then i_enable=1 and word 8'h40 with seed 8'h5A → LOAD next cycle with o_efm_data=8'h40 and o_seed=8'h5A; o_mod_valid=1 exactly 2+4 cycles after the handshake; o_update_cnt=1.
- Word presented 3 cycles into RUN with P_HOLD_CYCLES=16 → ready stays 0 until RUN cycle 16; accepted word 8'h41 appears the next cycle; o_mod_rst_n is never 0; o_seed unchanged.
- i_enable dropped mid-FLUSH → IDLE next cycle with o_mod_rst_n=0; i_enable reasserted → LOAD → FLUSH → RUN reusing the latched word, with no new handshake.
- i_rst pulsed in RUN → every output returns to its reset value on the next edge; a word is needed again before leaving IDLE.
- 256 accepted handshakes → o_update_cnt wraps to 0; 257 → 1.
- With DDSM_CTRL_DITHER_EN, word 8'h80 and seed 8'h00 → o_efm_data[7:1] stays constant, bit 0 follows the LFSR sequence from 16'h00FF; without the macro, o_efm_data stays 8'h80.
